// File: rtl/guess_evaluator.sv
// Mastermind turn evaluator: scores a guess
// against the secret and issues a turn command.
module guess_evaluator #(
  parameter int COLOR_W    = 3,
  parameter int NUM_COLORS = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 submit,
  input  logic [4*COLOR_W-1:0] guess,
  input  logic [4*COLOR_W-1:0] secret,
  input  logic                 secret_valid,
  input  logic [1:0]           game_over,
  output logic [1:0]           turn_cmd,
  output logic [2:0]           black,
  output logic [2:0]           white,
  output logic                 result_valid,
  output logic                 busy,
  output logic                 reject
);

  typedef enum logic [2:0] {
    IDLE, EXACT, COLOR, REPORT, HOLD
  } state_t;

  localparam logic [COLOR_W:0] NCOL =
    (COLOR_W+1)'(NUM_COLORS);
  localparam logic [COLOR_W-1:0] LAST =
    COLOR_W'(NUM_COLORS-1);

  state_t state, state_n;

  logic [4*COLOR_W-1:0] g_q, s_q;
  logic [1:0]           idx;
  logic [COLOR_W-1:0]   col;
  logic [2:0]           bacc, macc;
  logic [2:0]           cg, cs, mn, macc_n;
  logic                 legal, go, stop, hit;

  function automatic logic [2:0] cnt(
    input logic [4*COLOR_W-1:0] v,
    input logic [COLOR_W-1:0]   c
  );
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++)
      if (v[i*COLOR_W +: COLOR_W] == c)
        n = n + 3'd1;
    return n;
  endfunction

  // every guess peg must be a legal colour
  always_comb begin
    legal = 1'b1;
    for (int i = 0; i < 4; i++)
      if ({1'b0, guess[i*COLOR_W +: COLOR_W]}
          >= NCOL)
        legal = 1'b0;
  end

  assign go   = submit && secret_valid &&
                (game_over == 2'b00);
  assign stop = (game_over != 2'b00);
  assign hit  = (g_q[idx*COLOR_W +: COLOR_W] ==
                 s_q[idx*COLOR_W +: COLOR_W]);

  // per-colour overlap of guess and secret
  always_comb begin
    cg     = cnt(g_q, col);
    cs     = cnt(s_q, col);
    mn     = (cg < cs) ? cg : cs;
    macc_n = macc + mn;
  end

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // next state and Moore outputs
  always_comb begin
    state_n      = state;
    turn_cmd     = 2'b00;
    result_valid = 1'b0;
    busy         = 1'b0;
    unique case (state)
      IDLE: begin
        if (go)
          state_n = legal ? EXACT : HOLD;
      end
      EXACT: begin
        busy = 1'b1;
        if (stop)
          state_n = IDLE;
        else if (idx == 2'd3)
          state_n = COLOR;
      end
      COLOR: begin
        busy = 1'b1;
        if (stop)
          state_n = IDLE;
        else if (col == LAST)
          state_n = REPORT;
      end
      REPORT: begin
        busy         = 1'b1;
        result_valid = 1'b1;
        turn_cmd     = (bacc == 3'd4) ?
                       2'b10 : 2'b01;
        state_n      = HOLD;
      end
      HOLD: begin
        if (!submit)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // latches, accumulators and scored result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g_q    <= '0;
      s_q    <= '0;
      idx    <= '0;
      col    <= '0;
      bacc   <= '0;
      macc   <= '0;
      black  <= '0;
      white  <= '0;
      reject <= 1'b0;
    end else begin
      reject <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go && legal) begin
            g_q  <= guess;
            s_q  <= secret;
            idx  <= '0;
            col  <= '0;
            bacc <= '0;
            macc <= '0;
          end else if (go) begin
            reject <= 1'b1;
          end
        end
        EXACT: begin
          if (!stop) begin
            if (hit) bacc <= bacc + 3'd1;
            idx <= idx + 2'd1;
          end
        end
        COLOR: begin
          if (!stop) begin
            macc <= macc_n;
            col  <= col + 1'b1;
            if (col == LAST) begin
              black <= bacc;
              white <= macc_n - bacc;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_guess_evaluator.sv
// Scoreboard bench for guess_evaluator:
// model-predicted responses checked by a monitor.
module tb_guess_evaluator;

  localparam int CW = 3;
  localparam int NC = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        submit = 1'b0;
  logic        secret_valid = 1'b0;
  logic [11:0] guess = '0;
  logic [11:0] secret = '0;
  logic [1:0]  game_over = 2'b00;
  logic [1:0]  turn_cmd;
  logic [2:0]  black, white;
  logic        result_valid, busy, reject;

  guess_evaluator #(
    .COLOR_W(CW), .NUM_COLORS(NC)
  ) dut (
    .clk(clk), .reset(reset),
    .submit(submit), .guess(guess),
    .secret(secret),
    .secret_valid(secret_valid),
    .game_over(game_over),
    .turn_cmd(turn_cmd), .black(black),
    .white(white),
    .result_valid(result_valid),
    .busy(busy), .reject(reject)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rej;
    int         b;
    int         w;
    logic [1:0] cmd;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int resp_cnt = 0;
  int cmd_pulses = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, req);
    end
  endtask

  function automatic logic [11:0] pk(
    input int a, input int b,
    input int c, input int d);
    return {3'(d), 3'(c), 3'(b), 3'(a)};
  endfunction

  // Mastermind scoring from colour histograms
  function automatic exp_t model(
    input logic [11:0] s, input logic [11:0] g);
    exp_t e;
    int hs[8];
    int hg[8];
    int m;
    e.rej = 0; e.b = 0; e.w = 0; e.cmd = 2'b00;
    for (int c = 0; c < 8; c++) begin
      hs[c] = 0; hg[c] = 0;
    end
    for (int i = 0; i < 4; i++) begin
      int gp, sp;
      gp = int'(g[i*CW +: CW]);
      sp = int'(s[i*CW +: CW]);
      if (gp >= NC) e.rej = 1;
      if (gp == sp) e.b++;
      hg[gp]++;
      hs[sp]++;
    end
    if (e.rej) begin
      e.b = 0;
      return e;
    end
    m = 0;
    for (int c = 0; c < NC; c++)
      m += (hg[c] < hs[c]) ? hg[c] : hs[c];
    e.w   = m - e.b;
    e.cmd = (e.b == 4) ? 2'b10 : 2'b01;
    return e;
  endfunction

  // monitor: pop and compare on every response
  always @(negedge clk) begin
    if (!reset) begin
      chk("cmd_only_with_valid",
          32'(turn_cmd != 2'b00),
          32'(result_valid));
      if (turn_cmd != 2'b00) cmd_pulses++;
      if (result_valid || reject) begin
        resp_cnt++;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: rv=%0b rej=%0b cmd=%0d, expected none",
                   result_valid, reject, turn_cmd);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("resp_kind", 32'(reject),
              32'(e.rej));
          if (!e.rej) begin
            chk("black", 32'(black), e.b);
            chk("white", 32'(white), e.w);
            chk("turn_cmd", 32'(turn_cmd),
                32'(e.cmd));
          end
        end
      end
    end
  end

  // one turn; inputs scrambled right after accept
  task automatic do_turn(input logic [11:0] s,
                         input logic [11:0] g,
                         output int bc);
    int st;
    int k;
    q.push_back(model(s, g));
    st = resp_cnt;
    bc = 0;
    @(negedge clk);
    secret = s; guess = g;
    secret_valid = 1'b1; submit = 1'b1;
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) begin
        submit = 1'b0;
        guess  = 12'($urandom);
        secret = 12'($urandom);
      end
      if (busy) bc++;
      if (resp_cnt != st) break;
    end
    if (resp_cnt == st) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout: got 0 responses, expected 1");
      void'(q.pop_back());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_idle_outs(
    input string tag);
    chk({tag, "_black"}, 32'(black), 0);
    chk({tag, "_white"}, 32'(white), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_cmd"}, 32'(turn_cmd), 0);
    chk({tag, "_rv"}, 32'(result_valid), 0);
    chk({tag, "_rej"}, 32'(reject), 0);
  endtask

  initial begin
    int bc;
    int st;
    int cp;
    logic [11:0] g;
    repeat (2) @(negedge clk);
    check_idle_outs("rst_hold");
    reset = 1'b0;
    @(negedge clk);
    check_idle_outs("rst_rel");

    // exact win: 11 busy cycles, one 10 pulse
    cp = cmd_pulses;
    do_turn(pk(1,2,3,4), pk(1,2,3,4), bc);
    chk("win_busy_cycles", bc, 11);
    chk("win_pulses", cmd_pulses - cp, 1);

    // reset mid-COLOR aborts silently
    @(negedge clk);
    secret = pk(1,1,2,2); guess = pk(2,2,1,1);
    submit = 1'b1;
    @(negedge clk);
    submit = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle_outs("mid_rst");
    repeat (3) @(negedge clk);
    chk("mid_rst_noresp", 32'(q.size()), 0);

    do_turn(pk(1,1,2,2), pk(2,2,1,1), bc);
    do_turn(pk(1,2,3,4), pk(1,3,5,5), bc);
    do_turn(pk(0,1,2,3), pk(0,0,0,0), bc);
    do_turn(pk(0,1,2,3), pk(5,5,5,5), bc);

    // illegal colour
    cp = cmd_pulses;
    do_turn(pk(0,1,2,3), pk(1,2,7,3), bc);
    chk("rej_busy", bc, 0);
    chk("rej_pulses", cmd_pulses - cp, 0);

    // ignored submits
    for (int m = 0; m < 2; m++) begin
      st = resp_cnt;
      bc = 0;
      @(negedge clk);
      secret = pk(1,2,3,4); guess = pk(4,3,2,1);
      game_over    = (m == 0) ? 2'b01 : 2'b00;
      secret_valid = (m == 0);
      submit = 1'b1;
      repeat (6) begin
        @(negedge clk);
        if (busy) bc++;
      end
      submit = 1'b0;
      @(negedge clk);
      game_over = 2'b00; secret_valid = 1'b1;
      chk("ignored_busy", bc, 0);
      chk("ignored_resp", resp_cnt - st, 0);
    end

    // held submit gives a single command
    cp = cmd_pulses;
    q.push_back(model(pk(2,3,4,5), pk(2,4,3,0)));
    @(negedge clk);
    secret = pk(2,3,4,5); guess = pk(2,4,3,0);
    submit = 1'b1;
    repeat (30) @(negedge clk);
    submit = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_pulses", cmd_pulses - cp, 1);

    // abort by game_over keeps old score
    do_turn(pk(0,1,2,3), pk(0,0,0,0), bc);
    cp = cmd_pulses;
    @(negedge clk);
    secret = pk(1,2,3,4); guess = pk(1,2,3,4);
    submit = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) submit = 1'b0;
      if (k == 5) game_over = 2'b10;
    end
    repeat (2) @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_black", 32'(black), 1);
    chk("abort_white", 32'(white), 0);
    game_over = 2'b00;
    repeat (15) @(negedge clk);
    chk("abort_pulses", cmd_pulses - cp, 0);

    // randomized turns
    for (int t = 0; t < 40; t++) begin
      logic [11:0] s;
      for (int i = 0; i < 4; i++) begin
        s[i*CW +: CW] = 3'($urandom_range(NC-1));
        g[i*CW +: CW] = 3'($urandom_range(NC-1));
      end
      if ($urandom_range(9) == 0)
        g[$urandom_range(3)*CW +: CW] =
          3'($urandom_range(7, NC));
      if ($urandom_range(4) == 0) g = s;
      do_turn(s, g, bc);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
